// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: 32-step shift-add multiply and restoring divide.
// Optional MULDIV_FAST_MULT_EN routes mult/multu through a single-cycle multiplier.
module hilo_muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        mf_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic        dz_q, dz_d;
  logic [31:0] rs_q, rs_d;
  logic [31:0] opb_q, opb_d;
  // Multiply: full product. Divide: [63:32] partial remainder, [31:0] dividend/quotient.
  logic [63:0] work_q, work_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic        signed_op;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign signed_op = ~op[0];
  assign rs_mag    = (signed_op && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
  assign rt_mag    = (signed_op && rt_val[31]) ? (32'd0 - rt_val) : rt_val;

  assign mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opb_q} : 33'd0);

  // A successful trial subtraction always fits in 32 bits since the remainder stays below the divisor.
  assign rem_sh   = {work_q[63:32], work_q[31]};
  assign rem_ge   = rem_sh >= {1'b0, opb_q};
  assign rem_diff = rem_sh[31:0] - opb_q;

  assign prod_fix = neg_q ? (64'd0 - work_q) : work_q;
  assign quo_fix  = neg_q ? (32'd0 - work_q[31:0]) : work_q[31:0];
  assign rem_fix  = rem_neg_q ? (32'd0 - work_q[63:32]) : work_q[63:32];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    rs_d      = rs_q;
    opb_d     = opb_q;
    work_d    = work_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d      = op;
          neg_d     = signed_op & (rs_val[31] ^ rt_val[31]);
          rem_neg_d = signed_op & rs_val[31];
          dz_d      = (rt_val == 32'd0);
          rs_d      = rs_val;
          opb_d     = op[1] ? rt_mag : rs_mag;
          work_d    = {32'd0, (op[1] ? rs_mag : rt_mag)};
          cnt_d     = 5'd0;
          state_d   = StRun;
`ifdef MULDIV_FAST_MULT_EN
          if (!op[1]) begin
            work_d  = {32'd0, rs_mag} * {32'd0, rt_mag};
            state_d = StFin;
          end
`endif
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      StRun: begin
        if (op_q[1]) begin
          if (rem_ge) work_d = {rem_diff, work_q[30:0], 1'b1};
          else        work_d = {rem_sh[31:0], work_q[30:0], 1'b0};
        end else begin
          work_d = {mul_sum, work_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StFin;
      end
      StFin: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (!op_q[1]) begin
          {hi_d, lo_d} = prod_fix;
        end else if (dz_q) begin
          hi_d = rs_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      op_q      <= 2'd0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      rs_q      <= 32'd0;
      opb_q     <= 32'd0;
      work_q    <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      rs_q      <= rs_d;
      opb_q     <= opb_d;
      work_q    <= work_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign stall = busy & (start | mf_req | hi_we | lo_we);

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed self-checking bench for hilo_muldiv_sequencer.
module tb_hilo_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        mf_req;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int total = 0;
  int bad   = 0;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif

  hilo_muldiv_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .mf_req (mf_req),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done),
    .stall  (stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op and waits (bounded) for busy to drop; leaves time at the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cyc, output int done_cnt);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    step();
    start = 1'b0;
    busy_cyc = 0;
    done_cnt = 0;
    while (busy && busy_cyc < 100) begin
      busy_cyc++;
      step();
      if (done) done_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++; if (hi !== 32'd0)  begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
    total++; if (lo !== 32'd0)  begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    reset = 1'b0;
    step();
    hi_we = 1'b1; wdata = 32'h1234_5678;
    step();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    step();
    lo_we = 1'b0; mf_req = 1'b1;
    #1;
    total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL mthi: got %h want 12345678", hi); end
    total++; if (lo !== 32'hCAFE_F00D) begin bad++; $display("FAIL mtlo: got %h want cafef00d", lo); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL idle_mf_stall: got %b want 0", stall); end
    step();
    mf_req = 1'b0;
  endtask

  task automatic test_start_priority();
    int n;
    start = 1'b1; op = 2'b11; rs_val = 32'd100; rt_val = 32'd7;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    step();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL prio_hi: got %h want 12345678", hi); end
    total++; if (lo !== 32'hCAFE_F00D) begin bad++; $display("FAIL prio_lo: got %h want cafef00d", lo); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL prio_busy: got %b want 1", busy); end
    n = 0;
    while (!done && n < 100) begin n++; step(); end
    total++; if (n !== 33) begin bad++; $display("FAIL divu_latency: got %0d want 33", n); end
    total++; if (hi !== 32'd2)  begin bad++; $display("FAIL divu_hi: got %h want 2", hi); end
    total++; if (lo !== 32'd14) begin bad++; $display("FAIL divu_lo: got %h want e", lo); end
    step();
  endtask

  task automatic test_mult();
    int bc, dc;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, bc, dc);
    total++; if (bc !== MulLat) begin bad++; $display("FAIL mult_busy: got %0d want %0d", bc, MulLat); end
    total++; if (dc !== 1) begin bad++; $display("FAIL mult_done_cnt: got %0d want 1", dc); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    total++; if (lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse: got %b want 0", done); end
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
    total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo: got %h want 1", lo); end
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, bc, dc);
    total++; if (hi !== 32'h4000_0000) begin bad++; $display("FAIL mult_min_hi: got %h want 40000000", hi); end
    total++; if (lo !== 32'h0000_0000) begin bad++; $display("FAIL mult_min_lo: got %h want 0", lo); end
    step();
  endtask

  task automatic test_divide();
    int bc, dc;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, bc, dc);
    total++; if (bc !== 33) begin bad++; $display("FAIL div_busy: got %0d want 33", bc); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
    total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc);
    total++; if (hi !== 32'h0000_0000) begin bad++; $display("FAIL div_ovf_hi: got %h want 0", hi); end
    total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
    run_op(2'b11, 32'hFFFF_FFFF, 32'd3, bc, dc);
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL divu_big_hi: got %h want 0", hi); end
    total++; if (lo !== 32'h5555_5555) begin bad++; $display("FAIL divu_big_lo: got %h want 55555555", lo); end
    step();
  endtask

  task automatic test_div_zero();
    int bc, dc;
    run_op(2'b10, 32'd5, 32'd0, bc, dc);
    total++; if (bc !== 33) begin bad++; $display("FAIL dz_busy: got %0d want 33", bc); end
    total++; if (dc !== 1) begin bad++; $display("FAIL dz_done_cnt: got %0d want 1", dc); end
    total++; if (hi !== 32'd5) begin bad++; $display("FAIL dz_hi: got %h want 5", hi); end
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_lo: got %h want ffffffff", lo); end
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, bc, dc);
    total++; if (hi !== 32'hFFFF_FFFB) begin bad++; $display("FAIL dz_neg_hi: got %h want fffffffb", hi); end
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_neg_lo: got %h want ffffffff", lo); end
    step();
  endtask

  task automatic test_back_to_back();
    int n, stall_bad;
    start = 1'b1; op = 2'b11; rs_val = 32'd1000; rt_val = 32'd10;
    step();
    op = 2'b11; rs_val = 32'd50; rt_val = 32'd8; mf_req = 1'b1;
    n = 0;
    stall_bad = 0;
    while (!done && n < 100) begin
      if (stall !== 1'b1) stall_bad++;
      n++;
      step();
    end
    total++; if (n !== 33) begin bad++; $display("FAIL b2b_latency: got %0d want 33", n); end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL b2b_stall_run: got %0d low cycles want 0", stall_bad); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_stall_done: got %b want 0", stall); end
    total++; if (lo !== 32'd100) begin bad++; $display("FAIL b2b_first_lo: got %h want 64", lo); end
    step();
    start = 1'b0; mf_req = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got %b want 1", busy); end
    total++; if (hi !== 32'd0 || lo !== 32'd100) begin
      bad++; $display("FAIL b2b_first_keep: got %h/%h want 0/64", hi, lo);
    end
    n = 0;
    while (!done && n < 100) begin n++; step(); end
    total++; if (hi !== 32'd2) begin bad++; $display("FAIL b2b_second_hi: got %h want 2", hi); end
    total++; if (lo !== 32'd6) begin bad++; $display("FAIL b2b_second_lo: got %h want 6", lo); end
    step();
  endtask

  task automatic test_reset_mid();
    int dones;
    start = 1'b1; op = 2'b11; rs_val = 32'hFFFF_FFFF; rt_val = 32'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    #2;
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (hi !== 32'd0 || lo !== 32'd0) begin
      bad++; $display("FAIL midrst_hilo: got %h/%h want 0/0", hi, lo);
    end
    step();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL midrst_done: got %0d want 0", dones); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL midrst_lo_after: got %h want 0", lo); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; mf_req = 1'b0;
    test_reset();
    test_start_priority();
    test_mult();
    test_divide();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_sequencer.md
# hilo_muldiv_sequencer

Multi-cycle sequencer for the HI/LO multiply/divide resource of the five-stage MIPS pipeline. It accepts mult/multu/div/divu from the EX stage and runs an iterative shift-add or restoring-divide datapath for 32 iterations. It owns the architectural HI and LO registers and services mthi/mtlo writes. While busy, it raises a stall toward the hazard unit whenever the pipeline presents another HI/LO-dependent instruction.

## Interface
- No parameters. Data width is fixed at 32 bits.
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  EX holds a mult/multu/div/divu instruction
- op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu
- rs_val  in  32  multiplicand or dividend
- rt_val  in  32  multiplier or divisor
- hi_we  in  1  mthi in EX
- lo_we  in  1  mtlo in EX
- wdata  in  32  mthi/mtlo data
- mf_req  in  1  mfhi/mflo in EX
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: result written
- stall  out  1  freeze PC/nPC/IF-ID and bubble ID (to hazard unit)

## Operation
- States:
  - IDLE
  - RUN: 32 iterations, 5-bit count
  - FIN: sign fixup and HI/LO write
- IDLE + start: latch operands and op, compute magnitudes, then go to RUN with count=0.
  - Signed ops take two's-complement magnitudes. Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- IDLE, no start: hi_we loads HI from wdata; lo_we loads LO from wdata. Both may be set in the same cycle.
- start has priority over hi_we/lo_we in the same cycle; the writes are dropped.
- RUN multiply: 64-bit shift-add, one multiplier bit per cycle.
- RUN divide: restoring divide, one quotient bit per cycle, 33-bit partial remainder.
- RUN with count==31: go to FIN.
- FIN multiply: negate the 64-bit product if op=mult and the operand signs differ. HI=product[63:32], LO=product[31:0].
- FIN divide:
  - Quotient is negated if op=div and the signs differ.
  - Remainder takes the sign of the dividend.
  - HI=remainder, LO=quotient.
- Divide by zero (rt_val==0, detected at start): FIN writes HI=rs_val (raw) and LO=0xFFFFFFFF. No fixup is applied, and latency is unchanged.
- FIN: pulse done and go to IDLE.
- busy = (state != IDLE).
- stall = busy & (start | mf_req | hi_we | lo_we), combinational.
- While busy, start, hi_we and lo_we are ignored. The pipeline holds the instruction via stall.
- Reset, at any time including mid-operation: state=IDLE, hi=0, lo=0, busy=0, done=0, stall=0. The in-flight result is discarded.

## Timing
- start sampled at edge T:
  - busy is high after edge T through edge T+33.
  - HI/LO are updated at edge T+33.
  - done is high for the cycle following edge T+33.
- Latency: 33 cycles from start acceptance to result visibility.
- A start in the cycle done is high is accepted: back-to-back issue.
- mf_req in the cycle done is high does not stall and reads the new HI/LO.
- mthi/mtlo in IDLE: value visible after the next edge.

## Configuration
- MULDIV_FAST_MULT_EN defined:
  - mult/multu skip RUN and go IDLE→FIN, computing the product with a single-cycle 32x32 multiplier.
  - HI/LO are written at edge T+1; busy is high for 1 cycle.
  - Divides are unchanged.
- Undefined: all ops use the 33-cycle iterative path.

## Test plan
- Reset → hi=0, lo=0, busy=0, done=0, stall=0. hi_we with wdata=0x12345678, then mf_req → HI=0x12345678, stall=0.
- mult rs=0xFFFFFFFD (-3), rt=7 → busy for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB, with a single done pulse. With MULDIV_FAST_MULT_EN the same result arrives after 1 cycle.
- Divide cases:
  - divu 100/7 → LO=14, HI=2.
  - div 0xFFFFFFF9 (-7)/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- div 5/0 → after 33 cycles, HI=5, LO=0xFFFFFFFF.
- mf_req and a second start held during RUN → stall=1 until done. The second start is accepted in the done cycle, and the first result is not corrupted.
- Reset asserted 10 cycles into a divu → immediately busy=0, hi=lo=0. No done pulse follows.
